// File: rtl/id_ex_stage_pkg.sv
// Shared constants and types for the ID/EX pipeline register:
// forward-select codes, ALU opcodes and the E-stage control bundle.
package id_ex_stage_pkg;

    typedef enum logic [1:0] {
        FWD_REG = 2'b00,
        FWD_W   = 2'b01,
        FWD_M   = 2'b10
    } fwd_sel_e;

    localparam logic [2:0] ADD_OP = 3'b000;
    localparam logic [2:0] SUB_OP = 3'b001;
    localparam logic [2:0] MUL_OP = 3'b010;
    localparam logic [2:0] AND_OP = 3'b011;
    localparam logic [2:0] OR_OP  = 3'b100;

    typedef struct packed {
        logic [2:0] alu_control;
        logic       alu_src;
        logic       reg_write;
        logic       mem_to_reg;
        logic       mem_write;
        logic       valid;
    } ex_ctrl_t;

    localparam ex_ctrl_t BUBBLE = '{
        alu_control: ADD_OP,
        alu_src:     1'b0,
        reg_write:   1'b0,
        mem_to_reg:  1'b0,
        mem_write:   1'b0,
        valid:       1'b0
    };

endpackage

// File: rtl/id_ex_stage_forward_unit.sv
// Forward-select for one E-stage source operand: newest producer (M, then W) wins;
// x0 and unused operands always read the registered regfile value.
module forward_unit
    import id_ex_stage_pkg::*;
#(
    parameter int REG_ADDR_W = 5
) (
    input  logic [REG_ADDR_W-1:0] rs_i,
    input  logic                  use_i,
    input  logic [REG_ADDR_W-1:0] rd_m_i,
    input  logic                  reg_write_m_i,
    input  logic [REG_ADDR_W-1:0] rd_w_i,
    input  logic                  reg_write_w_i,
    output fwd_sel_e              sel_o
);

    always_comb begin
        sel_o = FWD_REG;
        if (use_i) begin
            if (reg_write_m_i && (rd_m_i != '0) && (rd_m_i == rs_i)) begin
                sel_o = FWD_M;
            end else if (reg_write_w_i && (rd_w_i != '0) && (rd_w_i == rs_i)) begin
                sel_o = FWD_W;
            end
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with M/W operand forwarding and load-use stall/bubble
// insertion, feeding the execute-stage ALU.
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int WORD_SIZE  = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  stallE,
    input  logic                  flushE,
    input  logic [WORD_SIZE-1:0]  rd1D,
    input  logic [WORD_SIZE-1:0]  rd2D,
    input  logic [WORD_SIZE-1:0]  immD,
    input  logic [REG_ADDR_W-1:0] rs1D,
    input  logic [REG_ADDR_W-1:0] rs2D,
    input  logic [REG_ADDR_W-1:0] rdD,
    input  logic                  useRs1D,
    input  logic                  useRs2D,
    input  logic [2:0]            ALUControlD,
    input  logic                  ALUSrcD,
    input  logic                  RegWriteD,
    input  logic                  MemToRegD,
    input  logic                  MemWriteD,
    input  logic                  validD,
    input  logic [WORD_SIZE-1:0]  aluResultM,
    input  logic [REG_ADDR_W-1:0] rdM,
    input  logic                  RegWriteM,
    input  logic [WORD_SIZE-1:0]  resultW,
    input  logic [REG_ADDR_W-1:0] rdW,
    input  logic                  RegWriteW,
    output logic [WORD_SIZE-1:0]  srcAE,
    output logic [WORD_SIZE-1:0]  srcBE,
    output logic [2:0]            ALUControlE,
    output logic [WORD_SIZE-1:0]  writeDataE,
    output logic [REG_ADDR_W-1:0] rdE,
    output logic                  RegWriteE,
    output logic                  MemToRegE,
    output logic                  MemWriteE,
    output logic                  validE,
    output logic                  stallD,
    output logic [1:0]            forwardAE,
    output logic [1:0]            forwardBE
);

    ex_ctrl_t              ctrl_q, ctrl_d;
    logic [WORD_SIZE-1:0]  rd1_q, rd1_d, rd2_q, rd2_d, imm_q, imm_d;
    logic [REG_ADDR_W-1:0] rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
    logic                  use_rs1_q, use_rs1_d, use_rs2_q, use_rs2_d;

    logic                  load_use;
    fwd_sel_e              sel_a, sel_b;
    logic [WORD_SIZE-1:0]  fwd_a, fwd_b;

    assign load_use = ctrl_q.valid && ctrl_q.mem_to_reg && ctrl_q.reg_write &&
                      (rd_q != '0) && validD &&
                      ((useRs1D && (rs1D == rd_q)) || (useRs2D && (rs2D == rd_q)));
    assign stallD   = load_use || stallE;

    // An external E hold outranks both the redirect flush and the load-use bubble.
    always_comb begin
        ctrl_d    = ctrl_q;
        rd1_d     = rd1_q;
        rd2_d     = rd2_q;
        imm_d     = imm_q;
        rs1_d     = rs1_q;
        rs2_d     = rs2_q;
        rd_d      = rd_q;
        use_rs1_d = use_rs1_q;
        use_rs2_d = use_rs2_q;
        if (stallE) begin
            ctrl_d = ctrl_q;
        end else if (flushE || load_use) begin
            ctrl_d    = BUBBLE;
            rd1_d     = '0;
            rd2_d     = '0;
            imm_d     = '0;
            rs1_d     = '0;
            rs2_d     = '0;
            rd_d      = '0;
            use_rs1_d = 1'b0;
            use_rs2_d = 1'b0;
        end else begin
            ctrl_d = '{
                alu_control: ALUControlD,
                alu_src:     ALUSrcD,
                reg_write:   RegWriteD && validD,
                mem_to_reg:  MemToRegD && validD,
                mem_write:   MemWriteD && validD,
                valid:       validD
            };
            rd1_d     = rd1D;
            rd2_d     = rd2D;
            imm_d     = immD;
            rs1_d     = rs1D;
            rs2_d     = rs2D;
            rd_d      = rdD;
            use_rs1_d = useRs1D;
            use_rs2_d = useRs2D;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_q    <= BUBBLE;
            rd1_q     <= '0;
            rd2_q     <= '0;
            imm_q     <= '0;
            rs1_q     <= '0;
            rs2_q     <= '0;
            rd_q      <= '0;
            use_rs1_q <= 1'b0;
            use_rs2_q <= 1'b0;
        end else begin
            ctrl_q    <= ctrl_d;
            rd1_q     <= rd1_d;
            rd2_q     <= rd2_d;
            imm_q     <= imm_d;
            rs1_q     <= rs1_d;
            rs2_q     <= rs2_d;
            rd_q      <= rd_d;
            use_rs1_q <= use_rs1_d;
            use_rs2_q <= use_rs2_d;
        end
    end

    forward_unit #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_a (
        .rs_i          (rs1_q),
        .use_i         (use_rs1_q),
        .rd_m_i        (rdM),
        .reg_write_m_i (RegWriteM),
        .rd_w_i        (rdW),
        .reg_write_w_i (RegWriteW),
        .sel_o         (sel_a)
    );

    forward_unit #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_b (
        .rs_i          (rs2_q),
        .use_i         (use_rs2_q),
        .rd_m_i        (rdM),
        .reg_write_m_i (RegWriteM),
        .rd_w_i        (rdW),
        .reg_write_w_i (RegWriteW),
        .sel_o         (sel_b)
    );

    always_comb begin
        fwd_a = rd1_q;
        fwd_b = rd2_q;
        case (sel_a)
            FWD_M:   fwd_a = aluResultM;
            FWD_W:   fwd_a = resultW;
            default: fwd_a = rd1_q;
        endcase
        case (sel_b)
            FWD_M:   fwd_b = aluResultM;
            FWD_W:   fwd_b = resultW;
            default: fwd_b = rd2_q;
        endcase
    end

    assign srcAE       = fwd_a;
    assign srcBE       = ctrl_q.alu_src ? imm_q : fwd_b;
    assign writeDataE  = fwd_b;
    assign forwardAE   = sel_a;
    assign forwardBE   = sel_b;
    assign ALUControlE = ctrl_q.alu_control;
    assign rdE         = rd_q;
    assign RegWriteE   = ctrl_q.reg_write;
    assign MemToRegE   = ctrl_q.mem_to_reg;
    assign MemWriteE   = ctrl_q.mem_write;
    assign validE      = ctrl_q.valid;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed scenarios plus randomized traffic
// compared against an instruction-level model of the E stage.
module tb_id_ex_stage;
    import id_ex_stage_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stallE, flushE;
    logic [31:0] rd1D, rd2D, immD;
    logic [4:0]  rs1D, rs2D, rdD;
    logic        useRs1D, useRs2D;
    logic [2:0]  ALUControlD;
    logic        ALUSrcD, RegWriteD, MemToRegD, MemWriteD, validD;
    logic [31:0] aluResultM, resultW;
    logic [4:0]  rdM, rdW;
    logic        RegWriteM, RegWriteW;
    logic [31:0] srcAE, srcBE, writeDataE;
    logic [2:0]  ALUControlE;
    logic [4:0]  rdE;
    logic        RegWriteE, MemToRegE, MemWriteE, validE, stallD;
    logic [1:0]  forwardAE, forwardBE;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    id_ex_stage #(.WORD_SIZE(32), .REG_ADDR_W(5)) dut (
        .clk(clk), .rst_n(rst_n), .stallE(stallE), .flushE(flushE),
        .rd1D(rd1D), .rd2D(rd2D), .immD(immD), .rs1D(rs1D), .rs2D(rs2D), .rdD(rdD),
        .useRs1D(useRs1D), .useRs2D(useRs2D), .ALUControlD(ALUControlD),
        .ALUSrcD(ALUSrcD), .RegWriteD(RegWriteD), .MemToRegD(MemToRegD),
        .MemWriteD(MemWriteD), .validD(validD),
        .aluResultM(aluResultM), .rdM(rdM), .RegWriteM(RegWriteM),
        .resultW(resultW), .rdW(rdW), .RegWriteW(RegWriteW),
        .srcAE(srcAE), .srcBE(srcBE), .ALUControlE(ALUControlE),
        .writeDataE(writeDataE), .rdE(rdE), .RegWriteE(RegWriteE),
        .MemToRegE(MemToRegE), .MemWriteE(MemWriteE), .validE(validE),
        .stallD(stallD), .forwardAE(forwardAE), .forwardBE(forwardBE)
    );

    // Instruction currently sitting in E, as the model sees it.
    typedef struct {
        logic        valid, regw, mtr, memw, alusrc, u1, u2;
        logic [2:0]  aluc;
        logic [31:0] rd1, rd2, imm;
        logic [4:0]  rs1, rs2, rd;
    } instr_t;

    instr_t m;

    function automatic instr_t empty_instr();
        instr_t e;
        e.valid = 0; e.regw = 0; e.mtr = 0; e.memw = 0; e.alusrc = 0;
        e.u1 = 0; e.u2 = 0; e.aluc = ADD_OP;
        e.rd1 = 0; e.rd2 = 0; e.imm = 0; e.rs1 = 0; e.rs2 = 0; e.rd = 0;
        return e;
    endfunction

    function automatic logic model_load_use();
        if (!(m.valid && m.mtr && m.regw && m.rd != 0 && validD)) return 1'b0;
        return (useRs1D && rs1D == m.rd) || (useRs2D && rs2D == m.rd);
    endfunction

    // Which stage holds the newest copy of a source register.
    function automatic logic [1:0] model_sel(input logic u, input logic [4:0] rs);
        if (!u || rs == 0) return 2'b00;
        if (RegWriteM && rdM == rs) return 2'b10;
        if (RegWriteW && rdW == rs) return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic [31:0] model_val(input logic [1:0] sel, input logic [31:0] regv);
        if (sel == 2'b10) return aluResultM;
        if (sel == 2'b01) return resultW;
        return regv;
    endfunction

    task automatic tick();
        @(posedge clk);
        if (!rst_n) begin
            m = empty_instr();
        end else if (stallE) begin
            m = m;
        end else if (flushE || model_load_use()) begin
            m = empty_instr();
        end else begin
            m.valid  = validD;
            m.regw   = RegWriteD & validD;
            m.mtr    = MemToRegD & validD;
            m.memw   = MemWriteD & validD;
            m.alusrc = ALUSrcD;
            m.aluc   = ALUControlD;
            m.rd1 = rd1D; m.rd2 = rd2D; m.imm = immD;
            m.rs1 = rs1D; m.rs2 = rs2D; m.rd = rdD;
            m.u1 = useRs1D; m.u2 = useRs2D;
        end
        #1;
    endtask

    task automatic idle_inputs();
        stallE = 0; flushE = 0;
        rd1D = 0; rd2D = 0; immD = 0; rs1D = 0; rs2D = 0; rdD = 0;
        useRs1D = 0; useRs2D = 0; ALUControlD = ADD_OP;
        ALUSrcD = 0; RegWriteD = 0; MemToRegD = 0; MemWriteD = 0; validD = 0;
        aluResultM = 0; rdM = 0; RegWriteM = 0;
        resultW = 0; rdW = 0; RegWriteW = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 0;
        m = empty_instr();
        validD = 1; RegWriteD = 1; rdD = 5'd3; rs1D = 5'd1; useRs1D = 1;
        rd1D = 32'hAAAA_0001; rd2D = 32'hBBBB_0002; ALUControlD = OR_OP;
        tick();
        #2 rst_n = 1;
        tick();
        checks++;
        if (validE !== 1'b1 || rdE !== 5'd3 || ALUControlE !== OR_OP) begin
            errors++;
            $display("FAIL reset_release_load: validE=%b rdE=%0d aluc=%0d, required 1/3/%0d", validE, rdE, ALUControlE, OR_OP);
        end
        #2 rst_n = 0;
        m = empty_instr();
        #1;
        checks++;
        if (srcAE !== 32'h0 || srcBE !== 32'h0 || writeDataE !== 32'h0 || ALUControlE !== ADD_OP ||
            validE !== 1'b0 || RegWriteE !== 1'b0 || MemToRegE !== 1'b0 || MemWriteE !== 1'b0 || rdE !== 5'd0) begin
            errors++;
            $display("FAIL reset_async: srcA=%h srcB=%h wd=%h aluc=%0d v=%b rw=%b m2r=%b mw=%b rd=%0d, required all 0",
                     srcAE, srcBE, writeDataE, ALUControlE, validE, RegWriteE, MemToRegE, MemWriteE, rdE);
        end
        $display("reset: async clear observed at %0t", $time);
        #1 rst_n = 1;
        tick();
        checks++;
        if (validE !== 1'b1 || srcAE !== 32'hAAAA_0001) begin
            errors++;
            $display("FAIL reset_first_edge: validE=%b srcA=%h, required 1/aaaa0001", validE, srcAE);
        end
    endtask

    task automatic test_back_to_back();
        idle_inputs();
        validD = 1; RegWriteD = 1; rdD = 5'd5; ALUControlD = ADD_OP;
        tick();
        idle_inputs();
        validD = 1; RegWriteD = 1; rdD = 5'd6; useRs1D = 1; rs1D = 5'd5; rd1D = 32'h0000_0099;
        tick();
        idle_inputs();
        rdM = 5'd5; RegWriteM = 1; aluResultM = 32'h0000_0011;
        #1;
        checks++;
        if (forwardAE !== 2'b10 || srcAE !== 32'h0000_0011) begin
            errors++;
            $display("FAIL b2b_fwd_m: forwardAE=%b srcA=%h, required 10/00000011", forwardAE, srcAE);
        end
        rdW = 5'd5; RegWriteW = 1; resultW = 32'h0000_0022;
        #1;
        checks++;
        if (forwardAE !== 2'b10 || srcAE !== 32'h0000_0011) begin
            errors++;
            $display("FAIL b2b_m_over_w: forwardAE=%b srcA=%h, required 10/00000011", forwardAE, srcAE);
        end
        RegWriteM = 0;
        #1;
        checks++;
        if (forwardAE !== 2'b01 || srcAE !== 32'h0000_0022) begin
            errors++;
            $display("FAIL b2b_fwd_w: forwardAE=%b srcA=%h, required 01/00000022", forwardAE, srcAE);
        end
        $display("back_to_back: x5 consumer srcA=%h", srcAE);
    endtask

    task automatic test_load_use();
        idle_inputs();
        validD = 1; RegWriteD = 1; MemToRegD = 1; rdD = 5'd7;
        tick();
        idle_inputs();
        validD = 1; RegWriteD = 1; rdD = 5'd8; useRs1D = 1; rs1D = 5'd2; rd1D = 32'h55;
        useRs2D = 1; rs2D = 5'd7; rd2D = 32'h66; ALUControlD = SUB_OP;
        #1;
        checks++;
        if (stallD !== 1'b1) begin
            errors++;
            $display("FAIL load_use_stall: stallD=%b, required 1", stallD);
        end
        tick();
        checks++;
        if (validE !== 1'b0 || stallD !== 1'b0 || RegWriteE !== 1'b0) begin
            errors++;
            $display("FAIL load_use_bubble: validE=%b stallD=%b rw=%b, required 0/0/0", validE, stallD, RegWriteE);
        end
        tick();
        rdM = 5'd7; RegWriteM = 1; aluResultM = 32'hDEAD_0007;
        #1;
        checks++;
        if (validE !== 1'b1 || rdE !== 5'd8 || forwardBE !== 2'b10 || srcBE !== 32'hDEAD_0007 || writeDataE !== 32'hDEAD_0007) begin
            errors++;
            $display("FAIL load_use_consumer: v=%b rd=%0d fwdB=%b srcB=%h wd=%h, required 1/8/10/dead0007/dead0007",
                     validE, rdE, forwardBE, srcBE, writeDataE);
        end
        $display("load_use: consumer srcB=%h", srcBE);
    endtask

    task automatic test_x0();
        idle_inputs();
        validD = 1; useRs1D = 1; rs1D = 5'd0; rd1D = 32'h0000_ABCD;
        tick();
        rdM = 0; RegWriteM = 1; aluResultM = 32'h1111_1111;
        rdW = 0; RegWriteW = 1; resultW = 32'h2222_2222;
        validD = 0;
        #1;
        checks++;
        if (forwardAE !== 2'b00 || srcAE !== 32'h0000_ABCD) begin
            errors++;
            $display("FAIL x0_no_fwd: forwardAE=%b srcA=%h, required 00/0000abcd", forwardAE, srcAE);
        end
        $display("x0: srcA=%h", srcAE);
    endtask

    task automatic test_stall_flush();
        idle_inputs();
        validD = 1; RegWriteD = 1; rdD = 5'd4; useRs1D = 1; rs1D = 5'd10; rd1D = 32'h1111;
        ALUControlD = MUL_OP;
        tick();
        for (int i = 0; i < 3; i++) begin
            stallE = 1;
            rdD = 5'($urandom_range(11, 31)); rd1D = $urandom; ALUControlD = AND_OP;
            #1;
            checks++;
            if (stallD !== 1'b1) begin
                errors++;
                $display("FAIL stall_stallD: cycle %0d stallD=%b, required 1", i, stallD);
            end
            tick();
            checks++;
            if (rdE !== 5'd4 || srcAE !== 32'h1111 || ALUControlE !== MUL_OP || validE !== 1'b1) begin
                errors++;
                $display("FAIL stall_hold: cycle %0d rd=%0d srcA=%h aluc=%0d v=%b, required 4/1111/%0d/1",
                         i, rdE, srcAE, ALUControlE, validE, MUL_OP);
            end
            $display("stall: cycle %0d held rdE=%0d", i, rdE);
        end
        idle_inputs();
        validD = 1; RegWriteD = 1; MemToRegD = 1; rdD = 5'd9;
        tick();
        idle_inputs();
        validD = 1; RegWriteD = 1; rdD = 5'd12; useRs1D = 1; rs1D = 5'd9; flushE = 1;
        #1;
        checks++;
        if (stallD !== 1'b1) begin
            errors++;
            $display("FAIL flush_lu_stallD: stallD=%b, required 1", stallD);
        end
        tick();
        checks++;
        if (validE !== 1'b0 || RegWriteE !== 1'b0 || MemToRegE !== 1'b0 || ALUControlE !== ADD_OP || rdE !== 5'd0) begin
            errors++;
            $display("FAIL flush_lu_bubble: v=%b rw=%b m2r=%b aluc=%0d rd=%0d, required 0/0/0/0/0",
                     validE, RegWriteE, MemToRegE, ALUControlE, rdE);
        end
        flushE = 0;
        $display("flush: bubble validE=%b", validE);
    endtask

    task automatic test_alusrc_imm();
        idle_inputs();
        validD = 1; RegWriteD = 1; rdD = 5'd13; ALUSrcD = 1; immD = 32'hFFFF_FFFC;
        useRs2D = 1; rs2D = 5'd3; rd2D = 32'h999;
        tick();
        idle_inputs();
        rdW = 5'd3; RegWriteW = 1; resultW = 32'h1234;
        #1;
        checks++;
        if (srcBE !== 32'hFFFF_FFFC || writeDataE !== 32'h1234 || forwardBE !== 2'b01) begin
            errors++;
            $display("FAIL alusrc_imm: srcB=%h wd=%h fwdB=%b, required fffffffc/00001234/01", srcBE, writeDataE, forwardBE);
        end
        $display("alusrc_imm: srcB=%h writeData=%h", srcBE, writeDataE);
    endtask

    task automatic test_random();
        logic [1:0]  sa, sb;
        logic [31:0] fa, fb;
        for (int n = 0; n < 300; n++) begin
            stallE = ($urandom_range(0, 5) == 0);
            flushE = ($urandom_range(0, 7) == 0);
            rd1D = $urandom; rd2D = $urandom; immD = $urandom;
            rs1D = 5'($urandom_range(0, 3)); rs2D = 5'($urandom_range(0, 3)); rdD = 5'($urandom_range(0, 3));
            useRs1D = 1'($urandom); useRs2D = 1'($urandom);
            ALUControlD = 3'($urandom_range(0, 4)); ALUSrcD = 1'($urandom);
            RegWriteD = 1'($urandom); MemToRegD = ($urandom_range(0, 2) == 0); MemWriteD = 1'($urandom);
            validD = ($urandom_range(0, 3) != 0);
            aluResultM = $urandom; rdM = 5'($urandom_range(0, 3)); RegWriteM = 1'($urandom);
            resultW = $urandom; rdW = 5'($urandom_range(0, 3)); RegWriteW = 1'($urandom);
            #2;
            sa = model_sel(m.u1, m.rs1);
            sb = model_sel(m.u2, m.rs2);
            fa = model_val(sa, m.rd1);
            fb = model_val(sb, m.rd2);
            checks++;
            if (forwardAE !== sa || forwardBE !== sb || srcAE !== fa || writeDataE !== fb ||
                srcBE !== (m.alusrc ? m.imm : fb)) begin
                errors++;
                $display("FAIL rand_operands: n=%0d fwdA=%b/%b fwdB=%b/%b srcA=%h/%h srcB=%h/%h wd=%h/%h (actual/required)",
                         n, forwardAE, sa, forwardBE, sb, srcAE, fa, srcBE, (m.alusrc ? m.imm : fb), writeDataE, fb);
            end
            checks++;
            if (validE !== m.valid || RegWriteE !== m.regw || MemToRegE !== m.mtr || MemWriteE !== m.memw ||
                ALUControlE !== m.aluc || rdE !== m.rd) begin
                errors++;
                $display("FAIL rand_ctrl: n=%0d v=%b/%b rw=%b/%b m2r=%b/%b mw=%b/%b aluc=%0d/%0d rd=%0d/%0d (actual/required)",
                         n, validE, m.valid, RegWriteE, m.regw, MemToRegE, m.mtr, MemWriteE, m.memw,
                         ALUControlE, m.aluc, rdE, m.rd);
            end
            checks++;
            if (stallD !== (model_load_use() || stallE)) begin
                errors++;
                $display("FAIL rand_stallD: n=%0d stallD=%b, required %b", n, stallD, (model_load_use() || stallE));
            end
            $display("rand %0d: validE=%b rdE=%0d srcA=%h srcB=%h stallD=%b", n, validE, rdE, srcAE, srcBE, stallD);
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_load_use();
        test_x0();
        test_stall_flush();
        test_alusrc_imm();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
